stream_rr_arbiter: RTL
======================

Name: stream_rr_arbiter

Overview:
Round-robin arbiter that shares one valid/ready output stream among NUM_IN requesting streams. Packets (framed by last) are never interleaved. The output is registered through an internal two-entry output stage, so that a downstream stall does not combinationally reach the requesters. It sits in front of a shared downstream consumer (DSP chain, DMA, or output FIFO) that several producers feed.

Parameters:
NUM_IN, 4, number of requesting streams (>=1)
WIDTH, 16, data width per beat
LOCK_PACKETS, 1, 1 = hold the grant until a last beat is accepted; 0 = re-arbitrate after every beat
ID_W, $clog2(NUM_IN) (min 1), localparam, width of the source index

Ports:
i_clock  in  1  clock, all logic on the rising edge
i_reset_n  in  1  synchronous reset, active-low
i_in_data  in  NUM_IN*WIDTH  packed requester data; slice k = bits [k*WIDTH +: WIDTH]
i_in_valid  in  NUM_IN  per-requester valid
i_in_last  in  NUM_IN  per-requester end-of-packet
o_in_ready  out  NUM_IN  per-requester ready; at most one bit high
o_out_data  out  WIDTH  output beat data
o_out_last  out  1  output end-of-packet
o_out_id  out  ID_W  index of the source of the output beat
o_out_valid  out  1  output valid
i_out_ready  in  1  downstream ready
o_busy  out  1  high when locked or either output-stage entry is full

Behaviour:
- One clock. Reset is synchronous and active-low. The clock is i_clock and the reset is i_reset_n.
- Reset values:
  - o_out_valid=0, o_out_data=0, o_out_last=0, o_out_id=0, o_busy=0.
  - o_in_ready=0 while i_reset_n=0 and in the first cycle after release. This is achieved with a registered stage_ready, reset to 0.
  - rr_ptr=0, state=ST_ARB, both stage entries empty.
- Handshake: a beat transfers when valid and ready are both high on a rising edge.
  - o_out_valid never depends on i_out_ready combinationally.
  - o_in_ready[k] = stage_ready & grant[k]. It may depend on i_in_valid.
- Grant selection in ST_ARB: grant is the first k with i_in_valid[k]=1, searching k = rr_ptr, rr_ptr+1, ... mod NUM_IN. Grant is one-hot or zero.
- FSM states:
  - ST_ARB:
    - If an accepted beat has last=0 and LOCK_PACKETS=1: lock_id <= grant index, go to ST_LOCK.
    - If the accepted beat has last=1, or LOCK_PACKETS=0: rr_ptr <= (grant index + 1) mod NUM_IN, stay in ST_ARB.
  - ST_LOCK:
    - grant = onehot(lock_id) regardless of the other valids.
    - A gap (i_in_valid[lock_id]=0) keeps the lock.
    - On an accepted last beat: rr_ptr <= (lock_id + 1) mod NUM_IN, go to ST_ARB.
- Output stage (main register plus skid register):
  - Accepted beat, main empty or i_out_ready=1: the beat goes to main.
  - Accepted beat, main full and i_out_ready=0: the beat goes to skid, skid_full <= 1.
  - skid_full=1 and i_out_ready=1: skid moves to main, skid_full <= 0.
  - stage_ready <= ~next_skid_full.
  - The {data, last, id} fields travel together.
- Latency and throughput:
  - Input-to-output latency is 1 cycle.
  - Sustained throughput is 1 beat/cycle across packet boundaries, with no bubble on a grant switch.
  - After a downstream stall releases, input acceptance resumes 1 cycle later.
- Boundary conditions:
  - All valids low: no grant, rr_ptr unchanged.
  - Single active requester: it is granted back-to-back.
  - NUM_IN=1: always grant 0, o_out_id=0.
  - rr_ptr wraps from NUM_IN-1 to 0.
  - A last beat with LOCK_PACKETS=1 that is also the first beat (1-beat packet) does not enter ST_LOCK.
  - Reset mid-packet: the lock is dropped, both entries are discarded, and all state returns to its reset values.
  - i_in_last is ignored for non-granted inputs.

Decomposition:
- Shared package stream_arb_pkg holds:
  - arb_state_t (ST_ARB=1'b0, ST_LOCK=1'b1);
  - a function rr_next(ptr, n) for the wrap-around increment.
- Sub-module rr_grant_select (combinational): NUM_IN valids plus rr_ptr in; one-hot grant and grant index out. It is instantiated once.

Test Plan:
- Reset hold: i_reset_n=0 for 3 cycles with all valids=1 -> o_in_ready=0 and o_out_valid=0 throughout, and in the first cycle after release; the first grant goes to input 0.
- Round-robin: NUM_IN=4, all inputs valid with single-beat packets (last=1), i_out_ready=1 -> o_out_id sequence 0,1,2,3,0,1, one beat/cycle, first output 1 cycle after the first accept.
- Packet lock: input 1 sends a 3-beat packet (data 0x11, 0x12, 0x13, last on the third), input 2 is valid throughout -> output 0x11, 0x12, 0x13 all with id=1, then input 2. o_in_ready[2]=0 until 0x13 is accepted.
- Lock with gap: input 0 drops valid for 2 cycles mid-packet while input 3 is valid -> no beat from input 3 until input 0's last is accepted.
- Backpressure: stream 0xA0.. from input 2 and hold i_out_ready=0 for 4 cycles -> exactly 2 beats buffered, o_in_ready[2]=0 after the second, no loss or duplication, order preserved on release.
- Reset mid-packet: assert reset after beat 2 of a 4-beat packet from input 3 -> outputs cleared; afterwards a valid on input 0 is granted (rr_ptr=0, lock gone).

Source files
------------

// File: rtl/stream_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : stream_arb_pkg
//  Description : Shared types and helpers for the stream round-robin arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
package stream_arb_pkg;

    // Arbiter FSM: free arbitration, or grant held for the rest of a packet
    typedef enum logic [0:0] {
        ST_ARB  = 1'b0,
        ST_LOCK = 1'b1
    } arb_state_t;

    // Round-robin pointer increment with wrap-around at n
    function automatic int rr_next(input int ptr, input int n);
        return (ptr + 1 >= n) ? 0 : ptr + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_grant_select.sv
`default_nettype none
// ============================================================================
//  Module      : rr_grant_select
//  Description : Combinational round-robin grant search. Scans the valids
//                starting at the pointer and returns the first hit as a
//                one-hot grant plus its binary index.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_grant_select #(
    parameter int NUM_IN = 4,
    parameter int ID_W   = 2
) (
    input  logic [NUM_IN-1:0] i_valid,
    input  logic [ID_W-1:0]   i_ptr,
    output logic [NUM_IN-1:0] o_grant,
    output logic [ID_W-1:0]   o_grant_idx
);

    logic w_found;

    // Index of the requester that sits offs positions after base, modulo NUM_IN
    function automatic logic [ID_W-1:0] wrap_idx(input logic [ID_W-1:0] base, input int offs);
        return ID_W'((int'(base) + offs) % NUM_IN);
    endfunction

    // Priority search beginning at the round-robin pointer
    always_comb begin
        o_grant     = '0;
        o_grant_idx = '0;
        w_found     = 1'b0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (!w_found && i_valid[wrap_idx(i_ptr, i)]) begin
                o_grant[wrap_idx(i_ptr, i)] = 1'b1;
                o_grant_idx                 = wrap_idx(i_ptr, i);
                w_found                     = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/stream_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : stream_rr_arbiter
//  Description : Round-robin arbiter sharing one valid/ready stream among
//                NUM_IN requesters. Packets are never interleaved when
//                LOCK_PACKETS=1. A main+skid output stage keeps downstream
//                ready off the requester-side combinational paths.
//  Revision    : 1.0 - initial release
// ============================================================================
module stream_rr_arbiter
    import stream_arb_pkg::*;
#(
    parameter  int NUM_IN       = 4,
    parameter  int WIDTH        = 16,
    parameter  int LOCK_PACKETS = 1,
    localparam int ID_W         = (NUM_IN > 1) ? $clog2(NUM_IN) : 1
) (
    input  logic                    i_clock,
    input  logic                    i_reset_n,
    input  logic [NUM_IN*WIDTH-1:0] i_in_data,
    input  logic [NUM_IN-1:0]       i_in_valid,
    input  logic [NUM_IN-1:0]       i_in_last,
    output logic [NUM_IN-1:0]       o_in_ready,
    output logic [WIDTH-1:0]        o_out_data,
    output logic                    o_out_last,
    output logic [ID_W-1:0]         o_out_id,
    output logic                    o_out_valid,
    input  logic                    i_out_ready,
    output logic                    o_busy
);

    // ---------------------------------------------------------------- state
    arb_state_t        r_state;
    logic [ID_W-1:0]   r_lock_id;
    logic [ID_W-1:0]   r_rr_ptr;

    // Output stage: main register drives the outputs, skid absorbs one beat
    logic [WIDTH-1:0]  r_main_data;
    logic              r_main_last;
    logic [ID_W-1:0]   r_main_id;
    logic              r_main_full;
    logic [WIDTH-1:0]  r_skid_data;
    logic              r_skid_last;
    logic [ID_W-1:0]   r_skid_id;
    logic              r_skid_full;
    logic              r_stage_ready;

    // ---------------------------------------------------------------- wires
    logic [WIDTH-1:0]  w_in_data [NUM_IN];
    logic [NUM_IN-1:0] w_arb_grant;
    logic [ID_W-1:0]   w_arb_idx;
    logic [NUM_IN-1:0] w_lock_onehot;
    logic [NUM_IN-1:0] w_grant;
    logic [ID_W-1:0]   w_sel_idx;
    logic [WIDTH-1:0]  w_sel_data;
    logic              w_sel_last;
    logic              w_accept;
    logic              w_next_skid_full;

    // Split the packed requester bus into per-requester words
    for (genvar k = 0; k < NUM_IN; k++) begin : g_unpack
        assign w_in_data[k] = i_in_data[k*WIDTH +: WIDTH];
    end

    rr_grant_select #(
        .NUM_IN (NUM_IN),
        .ID_W   (ID_W)
    ) u_grant_select (
        .i_valid     (i_in_valid),
        .i_ptr       (r_rr_ptr),
        .o_grant     (w_arb_grant),
        .o_grant_idx (w_arb_idx)
    );

    // While locked the owner keeps the grant even through valid gaps
    assign w_lock_onehot = NUM_IN'(1) << r_lock_id;
    assign w_grant       = (r_state == ST_LOCK) ? w_lock_onehot : w_arb_grant;
    assign w_sel_idx     = (r_state == ST_LOCK) ? r_lock_id : w_arb_idx;
    assign w_sel_data    = w_in_data[w_sel_idx];
    assign w_sel_last    = i_in_last[w_sel_idx];

    assign o_in_ready    = {NUM_IN{r_stage_ready}} & w_grant;
    assign w_accept      = r_stage_ready & (|(w_grant & i_in_valid));

    // Skid fills only when a beat arrives while main is stuck; it drains when downstream takes main
    assign w_next_skid_full = r_skid_full ? ~i_out_ready
                                          : (w_accept & r_main_full & ~i_out_ready);

    // Arbitration FSM: packet lock and round-robin pointer update on accepted beats
    always_ff @(posedge i_clock) begin
        if (!i_reset_n) begin
            r_state   <= ST_ARB;
            r_lock_id <= '0;
            r_rr_ptr  <= '0;
        end else if (w_accept) begin
            case (r_state)
                ST_ARB: begin
                    if ((LOCK_PACKETS != 0) && !w_sel_last) begin
                        r_lock_id <= w_arb_idx;
                        r_state   <= ST_LOCK;
                    end else begin
                        r_rr_ptr  <= ID_W'(rr_next(int'(w_arb_idx), NUM_IN));
                    end
                end
                ST_LOCK: begin
                    if (w_sel_last) begin
                        r_rr_ptr <= ID_W'(rr_next(int'(r_lock_id), NUM_IN));
                        r_state  <= ST_ARB;
                    end
                end
                default: r_state <= ST_ARB;
            endcase
        end
    end

    // Output stage: load main, spill to skid under stall, refill main from skid
    always_ff @(posedge i_clock) begin
        if (!i_reset_n) begin
            r_main_data   <= '0;
            r_main_last   <= 1'b0;
            r_main_id     <= '0;
            r_main_full   <= 1'b0;
            r_skid_data   <= '0;
            r_skid_last   <= 1'b0;
            r_skid_id     <= '0;
            r_skid_full   <= 1'b0;
            r_stage_ready <= 1'b0;
        end else begin
            r_skid_full   <= w_next_skid_full;
            r_stage_ready <= ~w_next_skid_full;
            if (r_skid_full) begin
                // No accept can occur here: stage_ready is low whenever skid holds a beat
                if (i_out_ready) begin
                    r_main_data <= r_skid_data;
                    r_main_last <= r_skid_last;
                    r_main_id   <= r_skid_id;
                end
            end else if (w_accept) begin
                if (!r_main_full || i_out_ready) begin
                    r_main_data <= w_sel_data;
                    r_main_last <= w_sel_last;
                    r_main_id   <= w_sel_idx;
                    r_main_full <= 1'b1;
                end else begin
                    r_skid_data <= w_sel_data;
                    r_skid_last <= w_sel_last;
                    r_skid_id   <= w_sel_idx;
                end
            end else if (i_out_ready) begin
                r_main_full <= 1'b0;
            end
        end
    end

    assign o_out_data  = r_main_data;
    assign o_out_last  = r_main_last;
    assign o_out_id    = r_main_id;
    assign o_out_valid = r_main_full;
    assign o_busy      = (r_state == ST_LOCK) | r_main_full | r_skid_full;

endmodule
`default_nettype wire
